// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | load_store_unit_pkg : shared funct3/state types and constants for the LSU |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    BYTE   = 3'b000,
    HALF   = 3'b001,
    WORD   = 3'b010,
    DOUBLE = 3'b011,
    BYTE_U = 3'b100,
    HALF_U = 3'b101,
    WORD_U = 3'b110
  } funct3_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } lsu_state_t;

  localparam logic [63:0] OUTPORT_ADDR = 64'hFFFC;

  // Stores have no unsigned forms, so any store with funct3[2] set is illegal.
  function automatic logic funct3_illegal(input logic [2:0] f3, input logic we,
                                          input int unsigned xlen);
    logic bad;
    bad = (f3 == 3'b111) || (we && f3[2]);
    if (xlen == 32) bad = bad || (f3 == DOUBLE) || (f3 == WORD_U);
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_align.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | lsu_align : byte-lane enables, store-data shift and load-data extension   |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module lsu_align
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  funct3,
  input  logic [$clog2(XLEN/8)-1:0]   off,
  input  logic [XLEN-1:0]             wdata,
  input  logic [2*XLEN-1:0]           rdata,
  output logic [2*(XLEN/8)-1:0]       be,
  output logic [2*XLEN-1:0]           wdata_sh,
  output logic [XLEN-1:0]             rdata_ext
);

  localparam int NB = XLEN / 8;
  localparam int MW = 2 * NB;
  localparam int WW = 2 * XLEN;

  logic [MW-1:0]   mask;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] dmask;
  logic            msb;

  // Two-beat views: the upper half of be/wdata_sh belongs to the second beat.
  always_comb begin
    raw = XLEN'(rdata >> {off, 3'b000});
    case (funct3[1:0])
      2'b00: begin mask = MW'(8'h01); dmask = XLEN'(8'hFF);         msb = raw[7];      end
      2'b01: begin mask = MW'(8'h03); dmask = XLEN'(16'hFFFF);      msb = raw[15];     end
      2'b10: begin mask = MW'(8'h0F); dmask = XLEN'(32'hFFFF_FFFF); msb = raw[31];     end
      default: begin mask = MW'(8'hFF); dmask = '1;                 msb = raw[XLEN-1]; end
    endcase
    be        = mask << off;
    wdata_sh  = WW'(wdata) << {off, 3'b000};
    rdata_ext = (raw & dmask) | ({XLEN{msb & ~funct3[2]}} & ~dmask);
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | load_store_unit : core-to-memory LSU with misaligned split and out-port   |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [63:0] OUTPORT_ADDR = load_store_unit_pkg::OUTPORT_ADDR,
  parameter int          OUTPORT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [XLEN-1:0]      req_addr,
  input  logic [XLEN-1:0]      req_wdata,
  output logic                 resp_valid,
  output logic [XLEN-1:0]      resp_rdata,
  output logic                 resp_err,
  output logic                 mem_req,
  input  logic                 mem_gnt,
  output logic                 mem_we,
  output logic [XLEN-1:0]      mem_addr,
  output logic [XLEN/8-1:0]    mem_be,
  output logic [XLEN-1:0]      mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic [OUTPORT_W-1:0] outport
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_t        state, state_nx;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   addr_q, wdata_q, beat0_q;
  logic              accept, illegal_in, to_outport, split;
  logic [XLEN-1:0]   base, rdata_ext;
  logic [2*NB-1:0]   be2;
  logic [2*XLEN-1:0] wd2, rpair;

  assign req_ready  = (state == IDLE);
  assign accept     = req_valid && req_ready;
  assign illegal_in = funct3_illegal(req_funct3, req_we, XLEN);
  assign to_outport = req_we && (req_addr == OUTPORT_ADDR[XLEN-1:0]);
  assign base       = {addr_q[XLEN-1:OFFW], OFFW'(0)};
  assign split      = |be2[2*NB-1:NB];
  // The beat arriving this cycle is used directly so the response needs no extra cycle.
  assign rpair = {(state == WAIT1) ? mem_rdata : {XLEN{1'b0}},
                  (state == WAIT0) ? mem_rdata : beat0_q};

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3    (f3_q),
    .off       (addr_q[OFFW-1:0]),
    .wdata     (wdata_q),
    .rdata     (rpair),
    .be        (be2),
    .wdata_sh  (wd2),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state)
      IDLE:  if (accept) state_nx = (illegal_in || to_outport) ? RESP : REQ0;
      REQ0: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base;
        mem_be    = be2[NB-1:0];
        mem_wdata = wd2[XLEN-1:0];
        if (mem_gnt) state_nx = WAIT0;
      end
      WAIT0: if (mem_rvalid) state_nx = split ? REQ1 : RESP;
      REQ1: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = base + XLEN'(NB);
        mem_be    = be2[2*NB-1:NB];
        mem_wdata = wd2[2*XLEN-1:XLEN];
        if (mem_gnt) state_nx = WAIT1;
      end
      WAIT1: if (mem_rvalid) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      beat0_q    <= '0;
      outport    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= (state_nx == RESP);
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      if (accept) begin
        we_q     <= req_we;
        f3_q     <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        resp_err <= illegal_in;
        if (!illegal_in && to_outport) outport <= req_wdata[OUTPORT_W-1:0];
      end
      if (state == WAIT0 && mem_rvalid) beat0_q <= mem_rdata;
      if ((state == WAIT0 || state == WAIT1) && mem_rvalid && state_nx == RESP && !we_q)
        resp_rdata <= rdata_ext;
    end
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Parametrised load/store unit between the core's execute stage and a generic request/grant data-memory port. It decodes LOAD_STORE_FNS funct3 (byte/half/word, signed and unsigned, plus doubleword when XLEN=64) and sizes byte lanes. Misaligned accesses are split into two aligned beats. Stores to the memory-mapped output port are handled locally in a register. XLEN is generic, so one RTL serves RV32 and RV64.

Parameters:
XLEN, 32, data/address width; legal values 32 or 64
OUTPORT_ADDR, 'hFFFC, output-port address, zero-extended to XLEN, full-width compare
OUTPORT_W, 32, output-port register width (<= XLEN)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  core request valid
req_ready  out  1  unit can accept; high only in IDLE
req_we  in  1  1=store, 0=load
req_funct3  in  3  LOAD_STORE_FNS funct3
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data, right-justified
resp_valid  out  1  one-cycle completion pulse; core must accept it
resp_rdata  out  XLEN  extended load data; 0 for stores and errors
resp_err  out  1  illegal funct3, valid with resp_valid
mem_req  out  1  memory request
mem_gnt  in  1  request accepted this cycle
mem_we  out  1  write enable
mem_addr  out  XLEN  aligned address (low log2(XLEN/8) bits zero)
mem_be  out  XLEN/8  byte enables
mem_wdata  out  XLEN  lane-shifted write data
mem_rvalid  in  1  read data valid, or write acknowledge
mem_rdata  in  XLEN  read data
outport  out  OUTPORT_W  output-port register

Behaviour:
- Reset (async, any state): go to IDLE; outport, resp_*, mem_req, mem_we, mem_be, mem_addr and mem_wdata all 0; req_ready=1.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_valid && req_ready captures all req_* fields. Next state:
  - Illegal funct3 -> RESP with err=1. Illegal means 011 or 110 when XLEN=32, 111 always, and for stores any of 1xx.
  - Store with addr == OUTPORT_ADDR -> outport <= req_wdata[OUTPORT_W-1:0] at the accept edge; no mem access; -> RESP.
  - All other requests -> REQ0. Loads from OUTPORT_ADDR go to memory.
- REQ0/REQ1: mem_req=1. addr, be, we and wdata are held stable until mem_gnt. On gnt, go to WAIT0/WAIT1 and drop mem_req in the next cycle.
- WAIT0: on mem_rvalid, capture mem_rdata. If the access is split, go to REQ1; otherwise go to RESP. WAIT1: on rvalid -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_valid, resp_rdata and resp_err are registered.
- Minimum latency with gnt and rvalid each in the first possible cycle: accept at T, REQ0 at T+1, WAIT0 at T+2, resp_valid at T+3. Split access: T+5. Outport store or error: resp_valid at T+1.
- Size: 1/2/4/8 bytes from funct3[1:0]. off = addr mod (XLEN/8).
- Split condition: off + size > XLEN/8.
  - Beat0: addr aligned down; be = size mask << off, truncated to the lanes present.
  - Beat1: aligned addr + XLEN/8, wrapping modulo 2^XLEN; carries the remaining low lanes.
  - wdata is shifted by the same lane offsets.
- Load data: concatenate {beat1, beat0}, shift right by off*8, truncate to size. funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
- mem_rvalid outside WAIT0/WAIT1 is ignored. This covers a stray response after reset.
- req_valid outside IDLE is ignored because req_ready=0.

Decomposition:
- Shared package LOAD_STORE_FNS is extended with:
  - funct3_t entries DOUBLE=3'b011 and WORD_U=3'b110
  - lsu_state_t enum
  - OUTPORT_ADDR, which remains the default for the parameter
- Sub-module lsu_align is purely combinational: funct3, off and data in; be, shifted wdata, and extended rdata out.

Test Plan:
- XLEN=32: mem[0x100]=0x80FF1234. LB at 0x103 -> resp_rdata 0xFFFFFF80. LBU at 0x103 -> 0x00000080. One beat each, mem_be=4'b1000.
- SW 0xAABBCCDD at 0x102 -> beat0 addr 0x100, be 4'b1100, wdata 0xCCDD0000. Beat1 addr 0x104, be 4'b0011, wdata 0x0000AABB. resp_valid at T+5 with zero-wait memory.
- mem[0x100]=0x11223344, mem[0x104]=0x55667788. LH at 0x103 -> 0xFFFF8811. LHU at 0x103 -> 0x00008811.
- SW 0xDEADBEEF at 0xFFFC -> outport=0xDEADBEEF after the accept edge, mem_req never asserted, resp_valid at T+1. LW from 0xFFFC -> issues a memory read.
- funct3=3'b011 with XLEN=32 -> resp_err=1, resp_rdata=0, no mem_req. XLEN=64: LD at 0x...7 splits across two beats. SW at 0xFFFFFFFE (XLEN=32) -> beat1 addr wraps to 0x00000000.
- mem_gnt withheld 3 cycles -> mem_addr/be/wdata stable throughout. rst asserted in WAIT0 -> mem_req=0 and req_ready=1 immediately, outport=0; a later stray rvalid produces no resp_valid.
